// File: rtl/seq_det_scheduler_pkg.sv
// seq_sched_pkg: FSM state encoding, default pattern constants and the
// detection-count width helper shared by the scheduler slice.
// Build option: define SEQ_DET_OVERLAP_EN for overlapping detection
// (the detection count then widens to cover every bit of a burst).
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;

    // Width needed to hold the largest possible per-burst detection count.
    function automatic int cnt_width(input int burst_len, input int pat_len);
        int max_det;
`ifdef SEQ_DET_OVERLAP_EN
        // Overlapped matches can complete on (almost) every accepted bit.
        max_det = (pat_len >= 1) ? burst_len : 0;
`else
        // Non-overlapped matches consume PAT_LEN bits each.
        max_det = burst_len / pat_len;
`endif
        return $clog2(max_det + 1);
    endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// seq_det_scheduler_if: requester streams, grants and the per-burst result
// handshake. master = sources/consumer side, slave = scheduler side.
// Count width follows SEQ_DET_OVERLAP_EN through seq_sched_pkg::cnt_width.
interface seq_det_scheduler_if
    import seq_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PAT_LEN   = DEF_PAT_LEN,
    parameter int BURST_LEN = 16,
    parameter int ID_W      = $clog2(N_REQ),
    parameter int CNT_W     = cnt_width(BURST_LEN, PAT_LEN)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] bit_valid;
    logic [N_REQ-1:0] bit_in;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] bit_ready;
    logic             detect;
    logic             res_valid;
    logic             res_ready;
    logic [ID_W-1:0]  res_id;
    logic [CNT_W-1:0] res_count;
    logic             res_abort;

    modport master (
        output req, bit_valid, bit_in, res_ready,
        input  grant, bit_ready, detect, res_valid, res_id, res_count, res_abort
    );

    modport slave (
        input  req, bit_valid, bit_in, res_ready,
        output grant, bit_ready, detect, res_valid, res_id, res_count, res_abort
    );
endinterface

// File: rtl/seq_det_scheduler_core.sv
// seq_det_core: Mealy serial pattern detector (MSB of PATTERN first).
// detect is combinational from the registered window plus the incoming bit.
// SEQ_DET_OVERLAP_EN: the match-spacing counter is not cleared on a match,
// so overlapping occurrences are all reported.
module seq_det_core
    import seq_sched_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic detect
);
    localparam int SW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] win;
    logic [PAT_LEN-1:0] win_nxt;
    logic [SW-1:0]      since;   // accepted bits since burst start / last match, saturating

    assign win_nxt = {win[PAT_LEN-2:0], bit_in};
    // The current bit counts toward the PAT_LEN-bit requirement.
    assign detect  = bit_valid && (win_nxt == PATTERN) && (since >= SW'(PAT_LEN - 1));

    // Window shift and match-spacing counter; cleared between bursts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win   <= '0;
            since <= '0;
        end else if (clr) begin
            win   <= '0;
            since <= '0;
        end else if (bit_valid) begin
            win <= win_nxt;
`ifdef SEQ_DET_OVERLAP_EN
            if (since != SW'(PAT_LEN)) since <= since + 1'b1;
`else
            if (detect)                     since <= '0;
            else if (since != SW'(PAT_LEN)) since <= since + 1'b1;
`endif
        end
    end
endmodule

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin time-sharing of one serial detector among
// N_REQ requesters, BURST_LEN bits per grant, per-burst result handshake.
// Build option SEQ_DET_OVERLAP_EN (see seq_det_core / seq_sched_pkg).
module seq_det_scheduler
    import seq_sched_pkg::*;
#(
    parameter int                 N_REQ     = 4,
    parameter int                 PAT_LEN   = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN   = DEF_PATTERN,
    parameter int                 BURST_LEN = 16,
    parameter int                 ID_W      = $clog2(N_REQ),
    parameter int                 CNT_W     = cnt_width(BURST_LEN, PAT_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    seq_det_scheduler_if.slave  bus
);
    localparam int BIT_W = $clog2(BURST_LEN + 1);

    state_t           state;
    logic [N_REQ-1:0] grant_q;
    logic [ID_W-1:0]  g_idx;
    logic [ID_W-1:0]  rr_ptr;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] det_cnt;
    logic             abort_q;

    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  idx;
    logic             found;
    logic             g_req, g_valid, g_bit, accept, det;

    // Round-robin pick: first requesting lane at or after rr_ptr.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Lane mux; a dropped request blocks acceptance in that same cycle.
    assign g_req   = bus.req[g_idx];
    assign g_valid = bus.bit_valid[g_idx];
    assign g_bit   = bus.bit_in[g_idx];
    assign accept  = (state == RUN) && g_req && g_valid;

    seq_det_core #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clr       (state == IDLE),
        .bit_valid (accept),
        .bit_in    (g_bit),
        .detect    (det)
    );

    // Scheduler FSM: grant, burst counting, result hold and pointer advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            grant_q <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            bit_cnt <= '0;
            det_cnt <= '0;
            abort_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    det_cnt <= '0;
                    abort_q <= 1'b0;
                    if (found) begin
                        grant_q <= N_REQ'(1) << pick;
                        g_idx   <= pick;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (!g_req) begin
                        abort_q <= 1'b1;
                        state   <= REPORT;
                    end else if (g_valid) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (det && (det_cnt != '1)) det_cnt <= det_cnt + 1'b1;
                        if (bit_cnt == BIT_W'(BURST_LEN - 1)) state <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        grant_q <= '0;
                        rr_ptr  <= (int'(g_idx) == N_REQ - 1) ? '0 : g_idx + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.bit_ready = (state == RUN) ? grant_q : '0;
    assign bus.detect    = det;
    assign bus.res_valid = (state == REPORT);
    assign bus.res_id    = g_idx;
    assign bus.res_count = det_cnt;
    assign bus.res_abort = abort_q;
endmodule
